// File: rtl/led_pio_pkg.sv
// Shared register map for the blinking LED PIO.
package led_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

endpackage

// File: rtl/led_blink_pio_blink_timer.sv
// Free-running blink divider: phase toggles every PERIOD cycles, stopped when PERIOD is 0.
module blink_timer #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] period,
  input  logic             load,
  output logic             phase
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q + DIV_W'(1);
    phase_d = phase_q;
    // A PERIOD write restarts the cycle from a known dark phase.
    if (load || (period == '0)) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == period - DIV_W'(1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/led_blink_pio.sv
// Avalon-MM LED PIO with per-channel blink mask driven by a shared blink timer.
module led_blink_pio
  import led_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               DIV_W       = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic             wr_en;
  logic             period_load;
  logic             phase;

  assign wr_en       = chipselect & ~write_n;
  assign period_load = wr_en && (address == ADDR_PERIOD);

  always_comb begin
    data_d   = data_q;
    mask_d   = mask_q;
    period_d = period_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:     data_d   = writedata[WIDTH-1:0];
        ADDR_MASK:     mask_d   = writedata[WIDTH-1:0];
        ADDR_PERIOD:   period_d = writedata[DIV_W-1:0];
        ADDR_OUTSET:   data_d   = data_q | writedata[WIDTH-1:0];
        ADDR_OUTCLEAR: data_d   = data_q & ~writedata[WIDTH-1:0];
        default:       ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q   <= RESET_VALUE;
      mask_q   <= '0;
      period_q <= '0;
    end else begin
      data_q   <= data_d;
      mask_q   <= mask_d;
      period_q <= period_d;
    end
  end

  blink_timer #(.DIV_W(DIV_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .period (period_q),
    .load   (period_load),
    .phase  (phase)
  );

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata = 32'(data_q);
      ADDR_MASK:   readdata = 32'(mask_q);
      ADDR_PERIOD: readdata = 32'(period_q);
      ADDR_STATUS: readdata = {31'b0, phase};
      default:     readdata = '0;
    endcase
  end

  // Masked channels are gated by phase; unmasked channels follow DATA directly.
  assign out_port = (data_q & ~mask_q) | (data_q & mask_q & {WIDTH{phase}});

endmodule

// File: tb/tb_led_blink_pio.sv
// Scoreboard bench for led_blink_pio: stimulus queues expectations, a monitor compares them.
module tb_led_blink_pio;

  logic        clk;
  logic        clk_en;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  typedef struct {
    string       name;
    bit          chk_rd;
    logic [31:0] exp_rd;
    logic [7:0]  exp_port;
  } exp_t;

  exp_t exp_q[$];
  event smp_ev;
  int   total;
  int   passed;

  led_blink_pio #(.WIDTH(8), .RESET_VALUE(8'hA5), .DIV_W(24)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  // Monitor: every pending expectation is checked against the live outputs.
  initial begin
    exp_t it;
    forever begin
      @(negedge clk or smp_ev);
      while (exp_q.size() > 0) begin
        it = exp_q.pop_front();
        total++;
        if (out_port === it.exp_port) passed++;
        else $display("FAIL %s out_port got %h want %h", it.name, out_port, it.exp_port);
        if (it.chk_rd) begin
          total++;
          if (readdata === it.exp_rd) passed++;
          else $display("FAIL %s readdata got %h want %h", it.name, readdata, it.exp_rd);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "timeout");
  end

  // Called at posedge+1; the write lands on the next rising edge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // Clocked check: sampled by the monitor at the following falling edge.
  task automatic chk(input string nm, input logic [2:0] a, input logic [31:0] rd,
                     input logic [7:0] port);
    exp_t it;
    address = a;
    it.name = nm; it.chk_rd = 1'b1; it.exp_rd = rd; it.exp_port = port;
    exp_q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  // Immediate check with the clock held, for asynchronous-reset behaviour.
  task automatic chk_now(input string nm, input logic [2:0] a, input logic [31:0] rd,
                         input logic [7:0] port);
    exp_t it;
    address = a;
    #1;
    it.name = nm; it.chk_rd = 1'b1; it.exp_rd = rd; it.exp_port = port;
    exp_q.push_back(it);
    -> smp_ev;
    #1;
  endtask

  initial begin
    total = 0; passed = 0;
    clk_en = 1'b0;
    reset = 1'b1;
    address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    #3;
    chk_now("rst_data",   3'd0, 32'hA5, 8'hA5);
    chk_now("rst_mask",   3'd1, 32'h0,  8'hA5);
    chk_now("rst_period", 3'd2, 32'h0,  8'hA5);
    chk_now("rst_status", 3'd3, 32'h0,  8'hA5);
    chk_now("rst_addr4",  3'd4, 32'h0,  8'hA5);

    clk_en = 1'b1;
    @(posedge clk); #1;
    wr(3'd0, 32'h00);
    wr(3'd1, 32'hFF);
    chk("rst_wr_data", 3'd0, 32'hA5, 8'hA5);
    chk("rst_wr_mask", 3'd1, 32'h0,  8'hA5);
    reset = 1'b0;
    @(posedge clk); #1;

    wr(3'd0, 32'h0F);
    wr(3'd4, 32'hF0);
    wr(3'd5, 32'h81);
    chk("set_clr", 3'd0, 32'h7E, 8'h7E);
    chk("rsvd7",   3'd7, 32'h0,  8'h7E);

    wr(3'd0, 32'hFF);
    wr(3'd1, 32'h01);
    wr(3'd3, 32'h1);
    wr(3'd2, 32'h3);
    for (int k = 0; k < 12; k++) begin
      logic ph;
      ph = ((k / 3) % 2) == 1;
      chk($sformatf("blink3_%0d", k), 3'd3, {31'b0, ph}, {7'h7F, ph});
    end

    // Advance to phase=1, cnt=1 before reloading PERIOD.
    repeat (4) begin @(posedge clk); #1; end
    wr(3'd2, 32'h2);
    begin
      logic ph2 [5];
      ph2 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int k = 0; k < 5; k++)
        chk($sformatf("reload2_%0d", k), 3'd3, {31'b0, ph2[k]}, {7'h7F, ph2[k]});
    end
    chk("period_rd", 3'd2, 32'h2, 8'hFE);

    wr(3'd2, 32'h1);
    for (int k = 0; k < 4; k++) begin
      logic ph;
      ph = (k % 2) == 1;
      chk($sformatf("period1_%0d", k), 3'd3, {31'b0, ph}, {7'h7F, ph});
    end
    wr(3'd2, 32'h0);
    for (int k = 0; k < 3; k++)
      chk($sformatf("period0_%0d", k), 3'd3, 32'h0, 8'hFE);

    wr(3'd2, 32'h2);
    chk("pre_rst_a5", 3'd5, 32'h0, 8'hFE);
    chk("pre_rst_a4", 3'd4, 32'h0, 8'hFE);
    chk("pre_rst_ph", 3'd3, 32'h1, 8'hFF);
    #2;
    clk_en = 1'b0;
    reset = 1'b1;
    chk_now("arst_data",   3'd0, 32'hA5, 8'hA5);
    chk_now("arst_mask",   3'd1, 32'h0,  8'hA5);
    chk_now("arst_period", 3'd2, 32'h0,  8'hA5);
    chk_now("arst_status", 3'd3, 32'h0,  8'hA5);
    chk_now("arst_a6",     3'd6, 32'h0,  8'hA5);
    clk_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ph", 3'd3, 32'h0, 8'hA5);
    chk("post_rst_a5", 3'd5, 32'h0, 8'hA5);
    chk("post_rst_ph2", 3'd3, 32'h0, 8'hA5);

    @(negedge clk); #1;
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain pending got %0d want 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/led_blink_pio.md
LED_BLINK_PIO -- requirements
Module: led_blink_pio

Interface
REQ-001 Parameter WIDTH, default 8: number of output channels, legal range 1..32.
REQ-002 Parameter RESET_VALUE, default 0: reset value of DATA, WIDTH bits.
REQ-003 Parameter DIV_W, default 24: width of the PERIOD register and the blink counter, legal range 1..32.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 address  in  3  Avalon-MM word address.
REQ-007 chipselect  in  1  slave select.
REQ-008 write_n  in  1  active-low write strobe; write = chipselect & ~write_n.
REQ-009 writedata  in  32  write data; only bits [WIDTH-1:0] are used, or [DIV_W-1:0] for PERIOD.
REQ-010 readdata  out  32  read data, zero-extended.
REQ-011 out_port  out  WIDTH  LED drive outputs.

Function
REQ-012 Register map:
- 0 DATA (RW, WIDTH)
- 1 BLINK_MASK (RW, WIDTH)
- 2 PERIOD (RW, DIV_W)
- 3 STATUS (RO, bit0 = phase)
- 4 OUTSET (WO)
- 5 OUTCLEAR (WO)
- 6-7 reserved.
REQ-013 Write to 0, 1 or 2 loads the register from writedata on the same clock edge.
REQ-014 Write to 4 sets DATA = DATA | writedata[WIDTH-1:0]; write to 5 sets DATA = DATA & ~writedata[WIDTH-1:0].
REQ-015 Writes to 3, 6 and 7 are ignored.
REQ-016 Reads are combinational with zero wait states; readdata is independent of chipselect and write_n.
REQ-017 readdata returns 0 for addresses 4-7, and 0 in all bits above each register's width.
REQ-018 Blink counter cnt (DIV_W bits) and phase bit behaviour per clock:
- PERIOD == 0: cnt = 0, phase = 0 (blink stopped).
- Else if cnt == PERIOD-1: cnt = 0 and phase toggles.
- Else: cnt = cnt + 1.
REQ-019 The phase bit therefore toggles every PERIOD cycles. PERIOD = 1 toggles phase every cycle. cnt wraps only via the PERIOD-1 compare, never via overflow.
REQ-020 A write to PERIOD forces cnt = 0 and phase = 0 on that edge, overriding REQ-018.
REQ-021 out_port[i] = BLINK_MASK[i] ? (DATA[i] & phase) : DATA[i]. It is combinational from registers, so a write is visible on out_port in the cycle after the write edge.
REQ-022 Blinking channels with PERIOD == 0 drive 0 (phase held 0).
REQ-023 DATA, BLINK_MASK and PERIOD are never changed by the blink logic.

Reset
REQ-024 While reset = 1, asynchronously and independent of clk:
- DATA = RESET_VALUE
- BLINK_MASK = 0
- PERIOD = 0
- cnt = 0
- phase = 0
- out_port = RESET_VALUE
REQ-025 Writes during reset are ignored. Normal operation starts on the first rising edge after reset deasserts.
REQ-026 Reset asserted mid-blink abandons the current period; no state is retained.

Structure
REQ-027 Register address constants (ADDR_DATA .. ADDR_OUTCLEAR) live in the shared package led_pio_pkg.
REQ-028 The counter/phase logic is one sub-module, blink_timer (ports: clk, reset, period, load, phase). The register file and output mux stay in the top module.

Verification
REQ-029 Reset with WIDTH=8, RESET_VALUE=8'hA5 -> out_port = 8'hA5 and reads of 0/1/2/3 return 32'hA5/0/0/0, with no clock edge required.
REQ-030 Write DATA=8'h0F, then OUTSET=8'hF0, then OUTCLEAR=8'h81 -> DATA reads 32'h7E and out_port = 8'h7E one cycle after the last write.
REQ-031 DATA=8'hFF, BLINK_MASK=8'h01, PERIOD=3 -> out_port[0] holds 0 for 3 cycles, then 1 for 3 cycles, repeating; out_port[7:1] stays 7'h7F; STATUS bit0 tracks out_port[0].
REQ-032 Mid-blink, with phase=1 and cnt=1, write PERIOD=2 -> next cycle phase=0; phase toggles 2 cycles later; PERIOD reads 2.
REQ-033 PERIOD=1 -> phase toggles every cycle; then PERIOD=0 -> phase forced to 0 and blinking channels drive 0 thereafter.
REQ-034 Assert reset asynchronously between clock edges during blinking -> all outputs and registers reach reset values immediately; reads of addresses 4-7 return 0 before and after.
